queue_button_conditioner: RTL and testbench

Front-end stage for the queue counter. Takes the raw `up` (customer arrives) and `down` (customer served) push-buttons, synchronizes and debounces them, and emits clean single-cycle `inc_pulse` / `dec_pulse` events that the person up/down counter consumes directly. It replaces the divided-clock flip-flop debounce with a single-clock, counter-based conditioner and arbitrates simultaneous presses.

---
 rtl/queue_button_conditioner.sv | 195 +++++++++++++++++++
 tb/tb_queue_button_conditioner.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/queue_button_conditioner.sv
// Queue-counter button front end: 2-flop sync, counter debounce and up/down arbitration.
// Optional feature macro AUTO_REPEAT_EN adds a held-button auto-repeat per channel.
module queue_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 12500000
) (
  input  logic clk,
  input  logic reset,
  input  logic up,
  input  logic down,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic up_level,
  output logic down_level,
  output logic conflict
);

  localparam int unsigned MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned MAX_CYC = (MAX_DR > REPEAT_RATE) ? MAX_DR : REPEAT_RATE;
  localparam int          CW      = $clog2(MAX_CYC);
  // Transition fires when the count steps onto DEBOUNCE_CYCLES-1, i.e. from DEBOUNCE_CYCLES-2.
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  // Channel 0 is up (arrival), channel 1 is down (served).
  logic [1:0]    s1_q, s1_d;
  logic [1:0]    s2_q, s2_d;
  state_e        state_q [2];
  state_e        state_d [2];
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [1:0]    evt;
  logic [1:0]    level_q, level_d;
  logic          inc_q, inc_d;
  logic          dec_q, dec_d;
  logic          conflict_q, conflict_d;

  always_comb begin
    s1_d = {down, up};
    s2_d = s1_q;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= '0;
      s2_q <= '0;
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= IDLE;
        cnt_q[ch]   <= '0;
      end
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= state_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
      end
    end
  end

  // Next-state logic
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      state_d[ch] = state_q[ch];
      cnt_d[ch]   = cnt_q[ch];
      case (state_q[ch])
        IDLE: begin
          if (s2_q[ch]) begin
            state_d[ch] = PRESS_WAIT;
            cnt_d[ch]   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!s2_q[ch]) begin
            state_d[ch] = IDLE;
            cnt_d[ch]   = '0;
          end else if (cnt_q[ch] == DB_LAST) begin
            state_d[ch] = HELD;
            cnt_d[ch]   = '0;
          end else begin
            cnt_d[ch] = cnt_q[ch] + CW'(1);
          end
        end
        HELD: begin
          if (!s2_q[ch]) begin
            state_d[ch] = RELEASE_WAIT;
            cnt_d[ch]   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (s2_q[ch]) begin
            state_d[ch] = HELD;
            cnt_d[ch]   = '0;
          end else if (cnt_q[ch] == DB_LAST) begin
            state_d[ch] = IDLE;
            cnt_d[ch]   = '0;
          end else begin
            cnt_d[ch] = cnt_q[ch] + CW'(1);
          end
        end
        default: begin
          state_d[ch] = IDLE;
          cnt_d[ch]   = '0;
        end
      endcase
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);

  logic [CW-1:0] rpt_q [2];
  logic [CW-1:0] rpt_d [2];
  logic [1:0]    phase_q, phase_d;
  logic [1:0]    rpt_evt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= '0;
      for (int ch = 0; ch < 2; ch++) begin
        rpt_q[ch] <= '0;
      end
    end else begin
      phase_q <= phase_d;
      for (int ch = 0; ch < 2; ch++) begin
        rpt_q[ch] <= rpt_d[ch];
      end
    end
  end

  // Runs only while HELD stays HELD; any other cycle leaves it cleared so HELD entry restarts at 0.
  always_comb begin
    phase_d = '0;
    rpt_evt = '0;
    for (int ch = 0; ch < 2; ch++) begin
      rpt_d[ch] = '0;
      if ((state_q[ch] == HELD) && s2_q[ch]) begin
        if (rpt_q[ch] == (phase_q[ch] ? RATE_LAST : DELAY_LAST)) begin
          rpt_evt[ch] = 1'b1;
          phase_d[ch] = 1'b1;
        end else begin
          rpt_d[ch]   = rpt_q[ch] + CW'(1);
          phase_d[ch] = phase_q[ch];
        end
      end
    end
  end
`endif

  // Output logic: channel events, arbitration and next levels
  always_comb begin
    evt     = '0;
    level_d = '0;
    for (int ch = 0; ch < 2; ch++) begin
      evt[ch]     = (state_q[ch] == PRESS_WAIT) && s2_q[ch] && (cnt_q[ch] == DB_LAST);
      level_d[ch] = (state_d[ch] == HELD) || (state_d[ch] == RELEASE_WAIT);
    end
`ifdef AUTO_REPEAT_EN
    evt = evt | rpt_evt;
`endif
    inc_d      = evt[0] & ~evt[1];
    dec_d      = evt[1] & ~evt[0];
    conflict_d = evt[0] & evt[1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      conflict_q <= 1'b0;
      level_q    <= '0;
    end else begin
      inc_q      <= inc_d;
      dec_q      <= dec_d;
      conflict_q <= conflict_d;
      level_q    <= level_d;
    end
  end

  assign inc_pulse  = inc_q;
  assign dec_pulse  = dec_q;
  assign conflict   = conflict_q;
  assign up_level   = level_q[0];
  assign down_level = level_q[1];

endmodule

// File: tb/tb_queue_button_conditioner.sv
// Directed bench for queue_button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
// Event edges are logged by a monitor and compared against hand-computed expected edge numbers.
module tb_queue_button_conditioner;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RR = 3;

  logic clk = 1'b0;
  logic reset;
  logic up;
  logic down;
  logic inc_pulse;
  logic dec_pulse;
  logic up_level;
  logic down_level;
  logic conflict;

  int unsigned cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_inc_q[$];
  logic [31:0] exp_dec_q[$];
  logic [31:0] exp_conf_q[$];
  logic [31:0] got_inc_q[$];
  logic [31:0] got_dec_q[$];
  logic [31:0] got_conf_q[$];

  queue_button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .up        (up),
    .down      (down),
    .inc_pulse (inc_pulse),
    .dec_pulse (dec_pulse),
    .up_level  (up_level),
    .down_level(down_level),
    .conflict  (conflict)
  );

  // Clock and edge counter: after edge n, cyc == n.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log the edge number that registered each pulse.
  always @(negedge clk) begin
    if (inc_pulse) got_inc_q.push_back(cyc);
    if (dec_pulse) got_dec_q.push_back(cyc);
    if (conflict)  got_conf_q.push_back(cyc);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // A press accepted at edge acc, released by a drive at edge rel: with auto-repeat,
  // repeats land at acc+RD, then every RR, while s2 is still high (up to rel+2).
  task automatic expect_held(input int ch, input int unsigned acc, input int unsigned rel);
    int unsigned t;
    t = acc;
    if (ch == 0) exp_inc_q.push_back(t); else exp_dec_q.push_back(t);
`ifdef AUTO_REPEAT_EN
    t = acc + RD;
    while (t <= rel + 2) begin
      if (ch == 0) exp_inc_q.push_back(t); else exp_dec_q.push_back(t);
      t = t + RR;
    end
`endif
  endtask

  task automatic compare_q(input string tag, input int sel);
    logic [31:0] g[$];
    logic [31:0] e[$];
    int n;
    case (sel)
      0:       begin g = got_inc_q;  e = exp_inc_q;  end
      1:       begin g = got_dec_q;  e = exp_dec_q;  end
      default: begin g = got_conf_q; e = exp_conf_q; end
    endcase
    check($sformatf("%s_count", tag), g.size(), e.size());
    n = (g.size() < e.size()) ? g.size() : e.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_edge%0d", tag, i), g[i], e[i]);
    end
  endtask

  task automatic check_events(input string tag);
    compare_q({tag, "_inc"}, 0);
    compare_q({tag, "_dec"}, 1);
    compare_q({tag, "_conf"}, 2);
    exp_inc_q.delete();
    exp_dec_q.delete();
    exp_conf_q.delete();
    got_inc_q.delete();
    got_dec_q.delete();
    got_conf_q.delete();
  endtask

  initial begin
    int unsigned c;
    int unsigned r;

    // Reset held with up already pressed
    reset = 1'b0;
    up    = 1'b1;
    down  = 1'b0;
    step(3);
    check("rst_inc", inc_pulse, 0);
    check("rst_dec", dec_pulse, 0);
    check("rst_conflict", conflict, 0);
    check("rst_up_level", up_level, 0);
    check("rst_down_level", down_level, 0);

    reset = 1'b1;
    c = cyc;
    expect_held(0, c + 6, c + 10);
    step(5);
    check("pre_accept_level", up_level, 0);
    check("pre_accept_inc", inc_pulse, 0);
    step(1);
    check("accept_inc", inc_pulse, 1);
    check("accept_level", up_level, 1);
    step(1);
    check("accept_inc_single", inc_pulse, 0);
    step(3);
    check_events("reset_release");

    // Release: level falls DB+1 edges after the sampling edge, no pulse
    up = 1'b0;
    c = cyc;
    step(5);
    check("release_level_hold", up_level, 1);
    step(1);
    check("release_level_fall", up_level, 0);
    step(4);
    check_events("release");

    // 3-cycle glitch is shorter than DB and must be ignored
    up = 1'b1;
    step(3);
    up = 1'b0;
    step(12);
    check("glitch_level", up_level, 0);
    check_events("glitch");

    // Bounce 1-0-1-0 then hold: accepted DB stable cycles after the last rise
    c = cyc;
    up = 1'b1; step(1);
    up = 1'b0; step(1);
    up = 1'b1; step(1);
    up = 1'b0; step(1);
    up = 1'b1;
    expect_held(0, c + 10, c + 12);
    step(8);
    check("bounce_level", up_level, 1);
    check_events("bounce");
    up = 1'b0;
    step(10);
    check("bounce_release_level", up_level, 0);

    // Simultaneous press: conflict only, both levels rise
    up   = 1'b1;
    down = 1'b1;
    c = cyc;
    exp_conf_q.push_back(c + 6);
    step(6);
    check("both_conflict", conflict, 1);
    check("both_inc", inc_pulse, 0);
    check("both_dec", dec_pulse, 0);
    check("both_up_level", up_level, 1);
    check("both_down_level", down_level, 1);
    step(1);
    check("both_conflict_single", conflict, 0);
    step(4);
    check_events("both");
    up   = 1'b0;
    down = 1'b0;
    step(10);
    check("both_release_up", up_level, 0);
    check("both_release_down", down_level, 0);

    // Up held, down pressed 20 cycles later: independent events, no conflict
    up = 1'b1;
    c = cyc;
    expect_held(0, c + 6, c + 30);
    expect_held(1, c + 26, c + 30);
    step(20);
    down = 1'b1;
    step(7);
    check("seq_up_level", up_level, 1);
    check("seq_down_level", down_level, 1);
    step(3);
    up   = 1'b0;
    down = 1'b0;
    step(10);
    check_events("up_then_down");

    // Long hold: auto-repeat pulses when enabled, a single pulse otherwise
    up = 1'b1;
    c = cyc;
    expect_held(0, c + 6, c + 33);
    step(33);
    up = 1'b0;
    step(10);
    check_events("long_hold");

    // Reset while the press counter is at 2, then re-debounce from IDLE
    up = 1'b1;
    step(5);
    reset = 1'b0;
    step(1);
    check("mid_reset_inc", inc_pulse, 0);
    check("mid_reset_level", up_level, 0);
    step(2);
    reset = 1'b1;
    r = cyc;
    expect_held(0, r + 6, r + 13);
    step(5);
    check("mid_reset_no_early", inc_pulse, 0);
    step(1);
    check("mid_reset_accept", inc_pulse, 1);
    step(7);
    check("mid_reset_level_after", up_level, 1);
    up = 1'b0;
    step(10);
    check_events("mid_reset");

    step(5);
    check_events("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
